mac_acc_negator_pipe: RTL and testbench

Pipelined, parametrised successor to the MAC accumulator negation stage. It conditionally two's-complement-negates NUM_LANES accumulator lanes, which can be fused into groups of 1/2/4/8 lanes that share one carry chain and one sign flag. It adds valid/ready flow control, a 2-stage pipeline that splits the carry chain, and a per-group overflow flag for negating the most-negative value. It sits between the unsigned multiplier array and the accumulator adders.

---
 rtl/mac_acc_negator_pipe_pkg.sv | 25 ++
 rtl/mac_neg_lane.sv | 14 +
 rtl/mac_acc_negator_pipe.sv | 128 ++++++++++++
 tb/tb_mac_acc_negator_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_negator_pipe_pkg.sv
// Shared constants and helpers for the MAC accumulator negation pipeline.
package mac_acc_negator_pipe_pkg;

  localparam int unsigned MAC_CFG_SIGNED_BIT = 3;
  localparam int unsigned MAC_CFG_MODE_MSB   = 1;
  localparam int unsigned MAC_CFG_MODE_LSB   = 0;

  localparam logic [1:0] MAC_MODE_SINGLE = 2'b00;
  localparam logic [1:0] MAC_MODE_DUAL   = 2'b01;
  localparam logic [1:0] MAC_MODE_QUAD   = 2'b10;
  localparam logic [1:0] MAC_MODE_OCT    = 2'b11;

  // Lanes per group, clamped to the lanes actually present.
  function automatic int unsigned group_size(logic [1:0] mode, int unsigned num_lanes);
    int unsigned g;
    case (mode)
      MAC_MODE_SINGLE: g = 1;
      MAC_MODE_DUAL:   g = 2;
      MAC_MODE_QUAD:   g = 4;
      default:         g = 8;
    endcase
    return (g > num_lanes) ? num_lanes : g;
  endfunction

endpackage

// File: rtl/mac_neg_lane.sv
// One accumulator lane of the negator: inverted value plus carry-in, and a zero detect.
module mac_neg_lane #(
  parameter int unsigned LANE_WIDTH = 32
) (
  input  logic [LANE_WIDTH-1:0] x_i,
  input  logic                  cin_i,
  output logic [LANE_WIDTH-1:0] y_o,
  output logic                  zero_o
);

  assign y_o    = ~x_i + LANE_WIDTH'(cin_i);
  assign zero_o = (x_i == '0);

endmodule

// File: rtl/mac_acc_negator_pipe.sv
// Two-stage conditional two's-complement negator over fusable accumulator lanes,
// with valid/ready flow control and per-group most-negative overflow detection.
module mac_acc_negator_pipe
  import mac_acc_negator_pipe_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned LANE_WIDTH     = 32,
  parameter int unsigned MAC_CONF_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [MAC_CONF_WIDTH-1:0]       cfg,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
  input  logic [NUM_LANES-1:0]            in_neg,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_ovf,
  output logic [MAC_CONF_WIDTH-1:0]       out_cfg
);

  localparam int unsigned DataW = NUM_LANES * LANE_WIDTH;

  logic                      s1_valid_q;
  logic [DataW-1:0]          s1_data_q;
  logic [MAC_CONF_WIDTH-1:0] s1_cfg_q;
  logic [NUM_LANES-1:0]      s1_negsel_q, s1_zero_q, s1_msb_only_q;

  logic s2_adv, s1_adv, accept;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = en & rst & s1_adv;
  assign accept   = in_valid & in_ready;

  // Stage 1: per-lane -x and zero detect feed the group flags.
  logic [LANE_WIDTH-1:0] in_negx [NUM_LANES];
  logic [NUM_LANES-1:0]  in_zero, in_negsel, in_msb_only;
  int unsigned           in_gsize;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mac_neg_lane #(
      .LANE_WIDTH(LANE_WIDTH)
    ) u_lane (
      .x_i   (in_data[i*LANE_WIDTH +: LANE_WIDTH]),
      .cin_i (1'b1),
      .y_o   (in_negx[i]),
      .zero_o(in_zero[i])
    );
  end

  always_comb begin
    in_gsize    = group_size(cfg[MAC_CFG_MODE_MSB:MAC_CFG_MODE_LSB], NUM_LANES);
    in_negsel   = '0;
    in_msb_only = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      // Broadcast the top lane's sign flag to every lane of its group.
      for (int unsigned j = 0; j < NUM_LANES; j++) begin
        if (((j & ~(in_gsize - 1)) == (i & ~(in_gsize - 1))) &&
            ((j & (in_gsize - 1)) == in_gsize - 1)) begin
          in_negsel[i] = cfg[MAC_CFG_SIGNED_BIT] & in_neg[j];
        end
      end
      // Only 0 and 100..0 equal their own negation; zero is excluded.
      in_msb_only[i] = ((i & (in_gsize - 1)) == in_gsize - 1) && !in_zero[i] &&
                       (in_negx[i] == in_data[i*LANE_WIDTH +: LANE_WIDTH]);
    end
  end

  // Stage 2: carry prefix restarts at each group's bottom lane.
  int unsigned          s1_gsize;
  logic                 carry;
  logic [NUM_LANES-1:0] cin;
  logic [DataW-1:0]     s2_data;
  logic [NUM_LANES-1:0] s2_ovf;

  always_comb begin
    s1_gsize = group_size(s1_cfg_q[MAC_CFG_MODE_MSB:MAC_CFG_MODE_LSB], NUM_LANES);
    carry    = 1'b1;
    cin      = '0;
    s2_data  = s1_data_q;
    s2_ovf   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if ((i & (s1_gsize - 1)) == 0) carry = 1'b1;
      cin[i] = carry;
      carry  = carry & s1_zero_q[i];
      if (s1_negsel_q[i]) begin
        s2_data[i*LANE_WIDTH +: LANE_WIDTH] =
          ~s1_data_q[i*LANE_WIDTH +: LANE_WIDTH] + LANE_WIDTH'(cin[i]);
      end
      s2_ovf[i] = s1_negsel_q[i] & s1_msb_only_q[i] & cin[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_cfg_q      <= '0;
      s1_negsel_q   <= '0;
      s1_zero_q     <= '0;
      s1_msb_only_q <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_ovf       <= '0;
      out_cfg       <= '0;
    end else if (en) begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (accept) begin
        s1_data_q     <= in_data;
        s1_cfg_q      <= cfg;
        s1_negsel_q   <= in_negsel;
        s1_zero_q     <= in_zero;
        s1_msb_only_q <= in_msb_only;
      end
      if (s2_adv) out_valid <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        out_data <= s2_data;
        out_ovf  <= s2_ovf;
        out_cfg  <= s1_cfg_q;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_negator_pipe.sv
// Scoreboard bench for mac_acc_negator_pipe with 4 lanes of 8 bits.
module tb_mac_acc_negator_pipe;

  localparam int unsigned NL = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = NL * LW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] cfg = '0;
  logic [DW-1:0] in_data = '0;
  logic [NL-1:0] in_neg = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [NL-1:0] out_ovf;
  logic [CW-1:0] out_cfg;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NL-1:0] ovf;
    logic [CW-1:0] cfg;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_exp;
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] held;
  bit            rnd_done = 1'b0;

  always #5 clk = ~clk;

  mac_acc_negator_pipe #(
    .NUM_LANES     (NL),
    .LANE_WIDTH    (LW),
    .MAC_CONF_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cfg      (cfg),
    .in_data  (in_data),
    .in_neg   (in_neg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_cfg  (out_cfg)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-group arithmetic model: negate the concatenated group value.
  function automatic beat_t model(input logic [CW-1:0] c, input logic [DW-1:0] d,
                                  input logic [NL-1:0] n);
    beat_t       b;
    int          g;
    logic [63:0] v, mask, r;
    g = 1 << c[1:0];
    if (g > NL) g = NL;
    b.data = '0;
    b.ovf  = '0;
    b.cfg  = c;
    for (int k = 0; k < NL; k += g) begin
      v = '0;
      for (int l = 0; l < g; l++) v = v | (64'(d[(k+l)*LW +: LW]) << (l * LW));
      mask = (64'd1 << (g * LW)) - 64'd1;
      r = v;
      if (c[3] && n[k+g-1]) begin
        r = (~v + 64'd1) & mask;
        if (v == (64'd1 << (g * LW - 1))) b.ovf[k+g-1] = 1'b1;
      end
      for (int l = 0; l < g; l++) b.data[(k+l)*LW +: LW] = r[l*LW +: LW];
    end
    return b;
  endfunction

  // Inputs are stable at the falling edge, so a beat seen valid&ready here is taken next edge.
  always @(negedge clk) begin
    if (rst && en && in_valid && in_ready) exp_q.push_back(model(cfg, in_data, in_neg));
  end

  always @(negedge clk) begin
    if (rst && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("sb_data", 64'(out_data), 64'(mon_exp.data));
        check_eq("sb_ovf", 64'(out_ovf), 64'(mon_exp.ovf));
        check_eq("sb_cfg", 64'(out_cfg), 64'(mon_exp.cfg));
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive_beat(input logic [CW-1:0] c, input logic [DW-1:0] d,
                            input logic [NL-1:0] n);
    int waited;
    waited   = 0;
    cfg      = c;
    in_data  = d;
    in_neg   = n;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 200) begin
        check_eq("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    en        = 1'b1;
    out_ready = 1'b1;
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_ovf", 64'(out_ovf), 64'd0);
    check_eq("rst_out_cfg", 64'(out_cfg), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single mode, two-cycle latency.
    drive_beat(4'b1000, {8'h7F, 8'h80, 8'h00, 8'h05}, 4'b1111);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("lat_valid", 64'(out_valid), 64'd1);
    check_eq("single_data", 64'(out_data), 64'h8180_00FB);
    check_eq("single_ovf", 64'(out_ovf), 64'b0100);
    @(posedge clk);
    #1;

    // Dual, quad, mode-11 clamp, overflow, unsigned passthrough; back-to-back.
    drive_beat(4'b1001, {8'h00, 8'h01, 8'h01, 8'h00}, 4'b0011);
    drive_beat(4'b1010, {8'h00, 8'h00, 8'h00, 8'h01}, 4'b1000);
    drive_beat(4'b1011, {8'h00, 8'h00, 8'h00, 8'h01}, 4'b1000);
    drive_beat(4'b1010, {8'h80, 8'h00, 8'h00, 8'h00}, 4'b1000);
    drive_beat(4'b1011, {8'h80, 8'h00, 8'h00, 8'h00}, 4'b1000);
    drive_beat(4'b0010, {8'h78, 8'h56, 8'h34, 8'h12}, 4'b1111);
    drive_beat(4'b1001, {8'h80, 8'h00, 8'h00, 8'h00}, 4'b1010);
    in_valid = 1'b0;
    drain();

    // Backpressure then enable freeze.
    @(posedge clk);
    #1;
    fork
      begin
        for (int b = 0; b < 5; b++) drive_beat(4'b1001, 32'($urandom), 4'($urandom));
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        held = out_data;
        @(posedge clk);
        #1;
        en        = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check_eq("en0_frozen_data", 64'(out_data), 64'(held));
          check_eq("en0_valid_held", 64'(out_valid), 64'd1);
          check_eq("en0_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 en = 1'b1;
      end
    join
    drain();

    // Reset while a beat is presented.
    @(posedge clk);
    #1 out_ready = 1'b0;
    drive_beat(4'b1010, 32'h0000_0001, 4'b1000);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check_eq("rf_out_valid_before", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rf_out_valid", 64'(out_valid), 64'd0);
    check_eq("rf_out_data", 64'(out_data), 64'd0);
    check_eq("rf_out_ovf", 64'(out_ovf), 64'd0);
    check_eq("rf_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("rf_in_ready_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    drive_beat(4'b1000, {8'h7F, 8'h80, 8'h00, 8'h05}, 4'b1111);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rf_lat_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("rf_lat_valid", 64'(out_valid), 64'd1);
    check_eq("rf_data", 64'(out_data), 64'h8180_00FB);
    @(posedge clk);
    #1;

    // Random traffic with random downstream stalls.
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          drive_beat(4'($urandom), 32'($urandom), 4'($urandom));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
